// File: rtl/arilla_bus_arbiter.sv
// ============================================================================
// Module   : arilla_bus_arbiter
// Brief    : Round-robin owner arbitration of the shared arilla bus, with read
//            turnaround and optional burst-limited forced rotation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arilla_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int MAX_BURST   = 4,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic                   i_bus_read,
    input  logic                   i_bus_write,
    output logic [NUM_MASTERS-1:0] o_grant,
    output logic [IDX_W-1:0]       o_owner,
    output logic                   o_owner_valid,
    output logic                   o_turnaround
);

    localparam int c_cnt_w = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [c_cnt_w:0] c_cnt_max = (c_cnt_w + 1)'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWNED = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [IDX_W-1:0]         r_owner;
    logic [IDX_W-1:0]         w_owner_nxt;
    logic [IDX_W-1:0]         r_ptr;
    logic [IDX_W-1:0]         w_ptr_nxt;
    logic [c_cnt_w-1:0]       r_cnt;
    logic [c_cnt_w-1:0]       w_cnt_nxt;
    logic [NUM_MASTERS-1:0]   r_grant;
    logic                     r_owner_valid;
    logic                     r_turnaround;

    logic                     w_access;
    logic [c_cnt_w:0]         w_cnt_inc;
    logic [NUM_MASTERS-1:0]   w_owner_mask;
    logic                     w_owner_req;
    logic                     w_others;
    logic                     w_release;
    logic [IDX_W-1:0]         w_ptr_rel;
    logic [IDX_W:0]           w_pick_any;
    logic [IDX_W:0]           w_pick_rel;

    // Returns {found, index}: first set request at or after start, wrapping,
    // optionally skipping one excluded index.
    function automatic logic [IDX_W:0] f_pick(
        input logic [NUM_MASTERS-1:0] req,
        input logic [IDX_W-1:0]       start,
        input logic                   excl_en,
        input logic [IDX_W-1:0]       excl
    );
        logic [2*NUM_MASTERS-1:0] dbl;
        logic [IDX_W:0]           cand;
        logic                     found;
        logic [IDX_W-1:0]         sel;
        dbl   = {req, req} >> start;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = {1'b0, start} + (IDX_W + 1)'(i);
            if (cand >= (IDX_W + 1)'(NUM_MASTERS)) begin
                cand = cand - (IDX_W + 1)'(NUM_MASTERS);
            end
            if (!found && dbl[i] && !(excl_en && (cand[IDX_W-1:0] == excl))) begin
                found = 1'b1;
                sel   = cand[IDX_W-1:0];
            end
        end
        return {found, sel};
    endfunction

    always_comb begin
        w_access     = i_bus_read | i_bus_write;
        w_cnt_inc    = {1'b0, r_cnt} + (c_cnt_w + 1)'(w_access);
        w_owner_mask = NUM_MASTERS'(1) << r_owner;
        w_owner_req  = |(i_req & w_owner_mask);
        w_others     = |(i_req & ~w_owner_mask);
        w_release    = !w_owner_req ||
                       ((MAX_BURST != 0) && (w_cnt_inc >= c_cnt_max) && w_others);
        w_ptr_rel    = (r_owner == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_owner + IDX_W'(1);
        // A releasing owner searches from its successor, i.e. the updated pointer.
        w_pick_any   = f_pick(i_req, r_ptr, 1'b0, '0);
        w_pick_rel   = f_pick(i_req, w_ptr_rel, 1'b1, r_owner);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE, S_TURN: begin
                if (w_pick_any[IDX_W]) begin
                    w_state_nxt = S_OWNED;
                    w_owner_nxt = w_pick_any[IDX_W-1:0];
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_OWNED: begin
                if (!w_release) begin
                    w_cnt_nxt = (w_cnt_inc > c_cnt_max) ? c_cnt_max[c_cnt_w-1:0]
                                                        : w_cnt_inc[c_cnt_w-1:0];
                end else begin
                    w_ptr_nxt = w_ptr_rel;
                    if (i_bus_read) begin
                        // Read data returns next cycle; keep the bus ownerless.
                        w_state_nxt = S_TURN;
                    end else if (w_pick_rel[IDX_W]) begin
                        w_owner_nxt = w_pick_rel[IDX_W-1:0];
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner       <= '0;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_grant       <= '0;
            r_owner_valid <= 1'b0;
            r_turnaround  <= 1'b0;
        end else begin
            r_owner       <= w_owner_nxt;
            r_ptr         <= w_ptr_nxt;
            r_cnt         <= w_cnt_nxt;
            r_grant       <= (w_state_nxt == S_OWNED) ? (NUM_MASTERS'(1) << w_owner_nxt) : '0;
            r_owner_valid <= (w_state_nxt == S_OWNED);
            r_turnaround  <= (w_state_nxt == S_TURN);
        end
    end

    assign o_grant       = r_grant;
    assign o_owner       = r_owner;
    assign o_owner_valid = r_owner_valid;
    assign o_turnaround  = r_turnaround;

endmodule

`default_nettype wire

// File: tb/tb_arilla_bus_arbiter.sv
// ============================================================================
// Module   : tb_arilla_bus_arbiter
// Brief    : Self-checking bench for arilla_bus_arbiter (2- and 3-master builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arilla_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] reqA;
    logic       rdA, wrA;
    logic [1:0] grantA;
    logic [0:0] ownerA;
    logic       validA, turnA;
    logic [2:0] reqB;
    logic       rdB, wrB;
    logic [2:0] grantB;
    logic [1:0] ownerB;
    logic       validB, turnB;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per DUT: 0 = idle, 1 = owned, 2 = turnaround
    int m_state[2];
    int m_owner[2];
    int m_ptr[2];
    int m_cnt[2];

    always #5 clk = ~clk;

    arilla_bus_arbiter #(.NUM_MASTERS(2), .MAX_BURST(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_req(reqA), .i_bus_read(rdA), .i_bus_write(wrA),
        .o_grant(grantA), .o_owner(ownerA), .o_owner_valid(validA), .o_turnaround(turnA)
    );

    arilla_bus_arbiter #(.NUM_MASTERS(3), .MAX_BURST(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_req(reqB), .i_bus_read(rdB), .i_bus_write(wrB),
        .o_grant(grantB), .o_owner(ownerB), .o_owner_valid(validB), .o_turnaround(turnB)
    );

    function automatic int rr_search(input int req, input int start, input int excl, input int n);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (start + k) % n;
            if (((req >> idx) & 1) == 1 && idx != excl) return idx;
        end
        return -1;
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            m_state[d] = 0; m_owner[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0;
        end
    endtask

    task automatic m_step(input int d, input int n, input int mb, input int req,
                          input int rd, input int wr);
        int  c, nxt, others;
        bit  rel;
        if (m_state[d] == 1) begin
            others = req & ~(1 << m_owner[d]);
            nxt    = m_cnt[d] + (rd | wr);
            rel    = (((req >> m_owner[d]) & 1) == 0) || (mb != 0 && nxt >= mb && others != 0);
            if (!rel) begin
                m_cnt[d] = (nxt > mb) ? mb : nxt;
            end else begin
                m_ptr[d] = (m_owner[d] + 1) % n;
                if (rd != 0) begin
                    m_state[d] = 2;
                end else begin
                    c = rr_search(req, m_ptr[d], m_owner[d], n);
                    if (c >= 0) begin m_owner[d] = c; m_cnt[d] = 0; end
                    else m_state[d] = 0;
                end
            end
        end else begin
            c = rr_search(req, m_ptr[d], -1, n);
            if (c >= 0) begin m_state[d] = 1; m_owner[d] = c; m_cnt[d] = 0; end
            else m_state[d] = 0;
        end
    endtask

    task automatic tick();
        if (!rst_n) m_reset();
        else begin
            m_step(0, 2, 4, int'(reqA), int'(rdA), int'(wrA));
            m_step(1, 3, 2, int'(reqB), int'(rdB), int'(wrB));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        reqA = '0; rdA = 1'b0; wrA = 1'b0;
        reqB = '0; rdB = 1'b0; wrB = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        reqA = '0; rdA = 1'b0; wrA = 1'b0;
        reqB = '0; rdB = 1'b0; wrB = 1'b0;
        m_reset();
        #3;
        n_checks++;
        if ({grantA, ownerA, validA, turnA} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_a: got %b required 00000", {grantA, ownerA, validA, turnA});
        end
        n_checks++;
        if ({grantB, ownerB, validB, turnB} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_b: got %b required 0000000", {grantB, ownerB, validB, turnB});
        end
        do_reset();
    endtask

    task automatic test_grant_release();
        do_reset();
        reqA = 2'b01; tick();
        n_checks++;
        if ({grantA, ownerA, validA} !== 4'b0101) begin
            n_fail++;
            $display("FAIL grant_first: got %b required 0101", {grantA, ownerA, validA});
        end
        reqA = 2'b00; tick();
        n_checks++;
        if ({grantA, ownerA, validA} !== 4'b0000) begin
            n_fail++;
            $display("FAIL release_idle: got %b required 0000", {grantA, ownerA, validA});
        end
    endtask

    task automatic test_handoff();
        do_reset();
        reqA = 2'b11; tick();
        n_checks++;
        if (grantA !== 2'b01) begin
            n_fail++;
            $display("FAIL handoff_first: got %b required 01", grantA);
        end
        reqA = 2'b10; tick();
        n_checks++;
        if ({grantA, ownerA, turnA} !== 4'b1010) begin
            n_fail++;
            $display("FAIL handoff_nogap: got %b required 1010", {grantA, ownerA, turnA});
        end
        reqA = 2'b00; tick();
    endtask

    task automatic test_turnaround();
        do_reset();
        reqA = 2'b01; tick();
        reqA = 2'b10; rdA = 1'b1; tick();
        rdA = 1'b0;
        n_checks++;
        if ({grantA, ownerA, validA, turnA} !== 5'b00001) begin
            n_fail++;
            $display("FAIL turn_cycle: got %b required 00001", {grantA, ownerA, validA, turnA});
        end
        tick();
        n_checks++;
        if ({grantA, ownerA, validA, turnA} !== 5'b10110) begin
            n_fail++;
            $display("FAIL turn_newgrant: got %b required 10110", {grantA, ownerA, validA, turnA});
        end
        reqA = 2'b00; tick();
    endtask

    task automatic test_forced_rotation();
        do_reset();
        reqA = 2'b01; tick();
        reqA = 2'b11; wrA = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++;
            if (grantA !== ((k < 4) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL burst_write%0d: got %b required %b", k, grantA,
                         (k < 4) ? 2'b01 : 2'b10);
            end
        end
        wrA = 1'b0; reqA = 2'b00; tick();
        reqA = 2'b01; tick();
        wrA = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_checks++;
            if (grantA !== 2'b01) begin
                n_fail++;
                $display("FAIL burst_alone%0d: got %b required 01", k, grantA);
            end
        end
        wrA = 1'b0; reqA = 2'b11; tick();
        n_checks++;
        if (grantA !== 2'b10) begin
            n_fail++;
            $display("FAIL burst_saturated: got %b required 10", grantA);
        end
        reqA = 2'b00; tick();
    endtask

    task automatic test_three_rotation();
        int exp_seq[3] = '{1, 2, 0};
        int cur;
        do_reset();
        reqB = 3'b111; tick();
        n_checks++;
        if (grantB !== 3'b001) begin
            n_fail++;
            $display("FAIL rot_first: got %b required 001", grantB);
        end
        cur = 0;
        for (int k = 0; k < 3; k++) begin
            reqB = 3'b111 & ~(3'b001 << cur);
            wrB  = 1'b1;
            tick();
            n_checks++;
            if (grantB !== (3'b001 << exp_seq[k]) || $countones(grantB) > 1) begin
                n_fail++;
                $display("FAIL rot_step%0d: got %b required %b", k, grantB, 3'b001 << exp_seq[k]);
            end
            cur = exp_seq[k];
        end
        reqB = 3'b000; wrB = 1'b0; tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        reqA = 2'b01; tick();
        reqA = 2'b10; rdA = 1'b1; tick();
        rdA = 1'b0;
        #3;
        rst_n = 1'b0;
        m_reset();
        #1;
        n_checks++;
        if ({grantA, ownerA, validA, turnA} !== 5'b0) begin
            n_fail++;
            $display("FAIL areset_turn: got %b required 00000", {grantA, ownerA, validA, turnA});
        end
        #1;
        rst_n = 1'b1;
        reqA = 2'b11; tick();
        n_checks++;
        if (grantA !== 2'b01) begin
            n_fail++;
            $display("FAIL areset_turn_regrant: got %b required 01", grantA);
        end
        reqA = 2'b00; tick();
        reqB = 3'b010; tick();
        #3;
        rst_n = 1'b0;
        m_reset();
        #1;
        n_checks++;
        if ({grantB, validB, turnB} !== 5'b0) begin
            n_fail++;
            $display("FAIL areset_owned: got %b required 00000", {grantB, validB, turnB});
        end
        #1;
        rst_n = 1'b1;
        reqB = 3'b110; tick();
        n_checks++;
        if (grantB !== 3'b010) begin
            n_fail++;
            $display("FAIL areset_owned_regrant: got %b required 010", grantB);
        end
        reqB = 3'b000; tick();
    endtask

    task automatic test_random();
        logic [4:0] expA;
        logic [6:0] expB;
        int r;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 3) == 0) reqA = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) reqB = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 3); rdA = (r == 0); wrA = (r == 1);
            r = $urandom_range(0, 3); rdB = (r == 0); wrB = (r == 1);
            tick();
            expA = {(m_state[0] == 1) ? 2'(1 << m_owner[0]) : 2'b00, 1'(m_owner[0]),
                    m_state[0] == 1, m_state[0] == 2};
            expB = {(m_state[1] == 1) ? 3'(1 << m_owner[1]) : 3'b000, 2'(m_owner[1]),
                    m_state[1] == 1, m_state[1] == 2};
            n_checks++;
            if ({grantA, ownerA, validA, turnA} !== expA) begin
                n_fail++;
                $display("FAIL random_a cyc %0d: got %b required %b", cyc,
                         {grantA, ownerA, validA, turnA}, expA);
            end
            n_checks++;
            if ({grantB, ownerB, validB, turnB} !== expB || $countones(grantB) > 1) begin
                n_fail++;
                $display("FAIL random_b cyc %0d: got %b required %b", cyc,
                         {grantB, ownerB, validB, turnB}, expB);
            end
        end
    endtask

    initial begin
        test_reset();
        test_grant_release();
        test_handoff();
        test_turnaround();
        test_forced_rotation();
        test_three_rotation();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
